// File: rtl/forward_ctrl_unit_pkg.sv
// rtl/forward_ctrl_unit_pkg.sv - shared pipeline types and forwarding select codes
package forward_ctrl_unit_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_rec_t;

    // r0 is hard-wired zero, so a write to it never produces a forwardable value
    function automatic logic producer_hit(input logic              wr,
                                          input logic [REG_AW-1:0] rd,
                                          input logic [REG_AW-1:0] src);
        return wr && (rd == src) && (rd != '0);
    endfunction

endpackage

// File: rtl/forward_ctrl_unit_if.sv
// rtl/forward_ctrl_unit_if.sv - ID-stage hazard bus between pipeline and forwarding unit
interface forward_ctrl_unit_if #(
    parameter int CNT_W = 16
);
    import forward_ctrl_unit_pkg::*;

    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              flush_i;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        input  fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        output fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
    );

endinterface

// File: rtl/forward_ctrl_unit_fwd_match.sv
// rtl/forward_ctrl_unit_fwd_match.sv - select code for one source operand against EX/MEM producers
module fwd_match
    import forward_ctrl_unit_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic              ex_wr_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              mem_wr_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    output logic [1:0]        sel_o
);

    // The EX producer is the newer one, so it shadows an older MEM write to the same rd
    always_comb begin
        sel_o = FWD_RF;
        if (producer_hit(ex_wr_i, ex_rd_i, src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (producer_hit(mem_wr_i, mem_rd_i, src_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forward_ctrl_unit.sv
// rtl/forward_ctrl_unit.sv - forwarding select and load-use stall controller for the 5-stage pipeline
module forward_ctrl_unit
    import forward_ctrl_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    forward_ctrl_unit_if.slave  bus
);

    stage_rec_t        ex_q, ex_d;
    logic              mem_valid_q, mem_regwrite_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [1:0]        sel_a, sel_b;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall, bubble, ex_wr, mem_wr;

    assign ex_wr  = ex_q.valid & ex_q.regwrite;
    assign mem_wr = mem_valid_q & mem_regwrite_q;

    // A flushed ID instruction is dead, so it can never be the consumer of a load
    assign stall = bus.id_valid_i & ex_q.valid & ex_q.memread & ~bus.flush_i
                 & (ex_q.rd != '0)
                 & ((ex_q.rd == bus.id_rs_i) | (ex_q.rd == bus.id_rt_i));

    assign bubble = stall | bus.flush_i | ~bus.id_valid_i;

    fwd_match u_match_a (
        .src_i    (bus.id_rs_i),
        .ex_wr_i  (ex_wr),
        .ex_rd_i  (ex_q.rd),
        .mem_wr_i (mem_wr),
        .mem_rd_i (mem_rd_q),
        .sel_o    (sel_a)
    );

    fwd_match u_match_b (
        .src_i    (bus.id_rt_i),
        .ex_wr_i  (ex_wr),
        .ex_rd_i  (ex_q.rd),
        .mem_wr_i (mem_wr),
        .mem_rd_i (mem_rd_q),
        .sel_o    (sel_b)
    );

    always_comb begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (!bubble) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = bus.id_rd_i;
            ex_d.regwrite = bus.id_regwrite_i;
            ex_d.memread  = bus.id_memread_i;
            fwd_a_d       = sel_a;
            fwd_b_d       = sel_b;
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q           <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= '0;
            fwd_a_q        <= FWD_RF;
            fwd_b_q        <= FWD_RF;
            cnt_q          <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_valid_q    <= ex_q.valid;
            mem_regwrite_q <= ex_q.regwrite;
            mem_rd_q       <= ex_q.rd;
            fwd_a_q        <= fwd_a_d;
            fwd_b_q        <= fwd_b_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.fwd_a_o     = fwd_a_q;
    assign bus.fwd_b_o     = fwd_b_q;
    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// tb/tb_forward_ctrl_unit.sv - self-checking bench for forward_ctrl_unit
module tb_forward_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    forward_ctrl_unit_if #(.CNT_W(16)) bus ();

    forward_ctrl_unit #(.CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } instr_t;

    instr_t pipe[$];
    int     m_cnt;
    bit     obs_stall;
    int     saved_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        instr_t nop;
        nop = '{0, 0, 0, 0};
        pipe.delete();
        pipe.push_back(nop);
        pipe.push_back(nop);
        m_cnt = 0;
    endtask

    function automatic int src_sel(input int src);
        if (src == 0) return 0;
        for (int i = 0; i < 2; i++)
            if (pipe[i].v && pipe[i].rw && pipe[i].rd == src) return i + 1;
        return 0;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input int rd,
                         input bit rw, input bit mr, input bit fl);
        bus.id_valid_i    = v;
        bus.id_rs_i       = rs[4:0];
        bus.id_rt_i       = rt[4:0];
        bus.id_rd_i       = rd[4:0];
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
        bus.flush_i       = fl;
    endtask

    task automatic cyc(input bit v, input int rs, input int rt, input int rd,
                       input bit rw, input bit mr, input bit fl);
        instr_t in;
        int     ea, eb;
        bit     es;
        @(negedge clk);
        drive(v, rs, rt, rd, rw, mr, fl);
        #1;
        es = v && !fl && pipe[0].v && pipe[0].mr && pipe[0].rd != 0
             && (pipe[0].rd == rs || pipe[0].rd == rt);
        obs_stall = bus.stall_o;
        check("stall", {31'd0, bus.stall_o}, {31'd0, es});
        if (es || fl || !v) begin
            in = '{0, 0, 0, 0};
            ea = 0;
            eb = 0;
        end else begin
            in = '{1, rd, rw, mr};
            ea = src_sel(rs);
            eb = src_sel(rt);
        end
        if (es && m_cnt != 16'hFFFF) m_cnt++;
        pipe.push_front(in);
        void'(pipe.pop_back());
        @(posedge clk);
        #1;
        check("fwd_a", {30'd0, bus.fwd_a_o}, ea);
        check("fwd_b", {30'd0, bus.fwd_b_o}, eb);
        check("stall_cnt", {16'd0, bus.stall_cnt_o}, m_cnt);
    endtask

    initial begin
        bit     hold_v, hold_rw, hold_mr;
        int     hold_rs, hold_rt, hold_rd;

        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1), 0);
            #1;
            check("rst_fwd_a", {30'd0, bus.fwd_a_o}, 0);
            check("rst_fwd_b", {30'd0, bus.fwd_b_o}, 0);
            check("rst_stall", {31'd0, bus.stall_o}, 0);
            check("rst_cnt", {16'd0, bus.stall_cnt_o}, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // back-to-back ALU dependency
        cyc(1, 1, 2, 3, 1, 0, 0);
        cyc(1, 3, 4, 6, 1, 0, 0);
        check("b2b_a", {30'd0, bus.fwd_a_o}, 1);
        check("b2b_b", {30'd0, bus.fwd_b_o}, 0);

        // one-instruction gap
        cyc(1, 1, 2, 5, 1, 0, 0);
        cyc(1, 8, 9, 10, 1, 0, 0);
        cyc(1, 11, 5, 12, 1, 0, 0);
        check("gap_b", {30'd0, bus.fwd_b_o}, 2);

        // load-use
        cyc(1, 1, 1, 2, 1, 1, 0);
        saved_cnt = m_cnt;
        cyc(1, 2, 12, 13, 1, 0, 0);
        check("lu_stall", {31'd0, obs_stall}, 1);
        check("lu_bubble_a", {30'd0, bus.fwd_a_o}, 0);
        check("lu_bubble_b", {30'd0, bus.fwd_b_o}, 0);
        cyc(1, 2, 12, 13, 1, 0, 0);
        check("lu_restall", {31'd0, obs_stall}, 0);
        check("lu_fwd_a", {30'd0, bus.fwd_a_o}, 2);
        check("lu_cnt", {16'd0, bus.stall_cnt_o}, saved_cnt + 1);

        // register 0 never forwards
        cyc(1, 14, 15, 0, 1, 0, 0);
        cyc(1, 14, 15, 0, 1, 0, 0);
        cyc(1, 0, 0, 16, 1, 0, 0);
        check("r0_a", {30'd0, bus.fwd_a_o}, 0);
        check("r0_b", {30'd0, bus.fwd_b_o}, 0);

        // newest producer wins
        cyc(1, 14, 15, 7, 1, 0, 0);
        cyc(1, 14, 15, 7, 1, 0, 0);
        cyc(1, 7, 7, 17, 1, 0, 0);
        check("prio_a", {30'd0, bus.fwd_a_o}, 1);
        check("prio_b", {30'd0, bus.fwd_b_o}, 1);

        // flush beats stall
        cyc(1, 16, 17, 9, 1, 1, 0);
        saved_cnt = m_cnt;
        cyc(1, 9, 9, 18, 1, 0, 1);
        check("fl_stall", {31'd0, obs_stall}, 0);
        check("fl_bubble_a", {30'd0, bus.fwd_a_o}, 0);
        check("fl_cnt", {16'd0, bus.stall_cnt_o}, saved_cnt);
        cyc(1, 9, 20, 21, 1, 0, 0);
        check("fl_next_a", {30'd0, bus.fwd_a_o}, 2);

        // reset asserted mid-stall
        cyc(1, 1, 1, 4, 1, 1, 0);
        @(negedge clk);
        drive(1, 4, 5, 6, 1, 0, 0);
        #1;
        check("mid_stall_before", {31'd0, bus.stall_o}, 1);
        rst = 1'b1;
        #1;
        check("mid_stall_after", {31'd0, bus.stall_o}, 0);
        check("mid_cnt", {16'd0, bus.stall_cnt_o}, 0);
        check("mid_fwd_a", {30'd0, bus.fwd_a_o}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic on a small register set to provoke hazards
        hold_v = 0; hold_rs = 0; hold_rt = 0; hold_rd = 0; hold_rw = 0; hold_mr = 0;
        obs_stall = 0;
        for (int i = 0; i < 400; i++) begin
            if (!obs_stall) begin
                hold_v  = ($urandom_range(0, 7) != 0);
                hold_rs = $urandom_range(0, 3);
                hold_rt = $urandom_range(0, 3);
                hold_rd = $urandom_range(0, 3);
                hold_rw = ($urandom_range(0, 3) != 0);
                hold_mr = ($urandom_range(0, 2) == 0);
            end
            cyc(hold_v, hold_rs, hold_rt, hold_rd, hold_rw, hold_mr, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/forward_ctrl_unit.md
# forward_ctrl_unit

Forwarding and load-use hazard controller for the 5-stage pipeline. It keeps a shadow record of the destination registers in flight in EX, MEM and WB. For each instruction entering EX it produces registered 2-bit operand-select codes that drive the ALU-operand 3-to-1 muxes. It also raises a combinational stall when a load result is needed too early, and counts stall cycles for performance debug.

## Interface
- REG_AW, 5, register-address width
- CNT_W, 16, stall-counter width
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- id_valid_i  in  1  ID-stage instruction valid (0 = bubble)
- id_rs_i  in  REG_AW  ID source register A
- id_rt_i  in  REG_AW  ID source register B
- id_rd_i  in  REG_AW  ID destination register (already resolved rt/rd)
- id_regwrite_i  in  1  ID instruction writes the register file
- id_memread_i  in  1  ID instruction is a load
- flush_i  in  1  branch taken; kill the instruction leaving ID
- fwd_a_o  out  2  operand-A mux select for the instruction in EX
- fwd_b_o  out  2  operand-B mux select for the instruction in EX
- stall_o  out  1  hold PC and IF/ID, insert bubble into EX
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Select encoding is fixed:
  - 00 = register-file value.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB writeback data.
  - 11 is never driven.
- The internal records advance every clk_i edge:
  - EX record: rd, regwrite, memread, valid.
  - MEM record: rd, regwrite, valid.
  - EX record loads from the ID inputs, except that it loads a bubble (all zero) when stall_o=1, flush_i=1 or id_valid_i=0.
  - MEM record loads from the EX record.
- Forward decision is computed at the edge where an instruction enters EX, separately for rs→fwd_a_o and rt→fwd_b_o. A source matches a record when the record has valid=1, regwrite=1, rd==source and rd!=0.
  - Source matches the current EX record (it moves to MEM) → 01.
  - Otherwise source matches the current MEM record (it moves to WB) → 10.
  - Otherwise → 00.
  - The EX match has priority over the MEM match, because the newest producer wins.
- Register 0 never forwards.
- The WB→ID same-cycle case is not handled here; the register file is write-first.
- Load-use stall (combinational):
  - stall_o = id_valid_i & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==id_rs_i | EX.rd==id_rt_i).
  - stall_o is forced 0 when flush_i=1, because the ID instruction is dead.
- After a one-cycle stall the load sits in MEM, and the held instruction re-enters EX with select 10.
- Bubble entering EX: fwd_a_o and fwd_b_o are registered as 00.
- stall_cnt_o increments on each edge with stall_o=1 and saturates at all-ones.

## Timing
- Reset (async, rst_i=1): all records invalid, fwd_a_o=00, fwd_b_o=00, stall_cnt_o=0. stall_o=0 follows combinationally from the invalid EX record.
- fwd_*_o are registered: valid for exactly the cycle in which the instruction occupies EX, one edge after it was presented on the id_* inputs.
- stall_o has zero latency and is combinational from the id_* inputs and the EX record.
  - There is no path from fwd_*_o to stall_o.
  - Stall lasts exactly one cycle per load-use pair.
- Stall and flush in the same cycle: flush wins. stall_o=0, EX receives a bubble, and the counter does not increment.
- Back-to-back producers to the same rd: selects 01, never 10.
- rst_i asserted mid-stall: stall_o drops immediately and the records clear asynchronously.

## Structure
- Shared pipeline package holds:
  - The select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - REG_AW.
  - The stage-record typedef {valid, rd, regwrite, memread}.
- One natural sub-module, fwd_match: combinational compare of one source against the two records, returning a 2-bit select. It is instantiated twice, for A and B.

## Test plan
- Reset: hold rst_i=1 with random inputs → fwd_a_o=00, fwd_b_o=00, stall_o=0, stall_cnt_o=0.
- Back-to-back ALU dependency: add r3←… then sub …←r3,r4 → second instruction's EX cycle shows fwd_a_o=01, fwd_b_o=00.
- Gap of one instruction: producer of r5, independent instruction, then consumer rt=r5 → fwd_b_o=10.
- Load-use: lw r2 then add rs=r2 → stall_o=1 for one cycle, EX bubble with selects 00, then fwd_a_o=10. stall_cnt_o increments by 1.
- Register 0 and priority:
  - Producers write r0 → consumer of r0 gets 00.
  - Producers r7 in both MEM and EX → consumer gets 01.
- Flush plus stall in the same cycle: load in EX, dependent instruction in ID, flush_i=1 → stall_o=0, next EX is a bubble, stall_cnt_o unchanged.
